io_bridge_arb: RTL and testbench



---
 rtl/io_pkg.sv | 18 +
 rtl/io_bridge_arb_rr_arbiter.sv | 30 +++
 rtl/io_bridge_arb.sv | 185 ++++++++++++++++++
 tb/tb_io_bridge_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and helpers for the I/O bridge arbiter.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_NACK = 2'd2
  } io_state_e;

  // Default I/O window tag decoded from the upper address bits.
  localparam logic [11:0] IO_BASE_DEF = 12'hFFD;

  // Pick the 32-bit lane of a 64-bit word; hi selects the upper half.
  function automatic logic [31:0] lane_steer(input logic hi, input logic [63:0] dat);
    return hi ? dat[63:32] : dat[31:0];
  endfunction

endpackage

// File: rtl/io_bridge_arb_rr_arbiter.sv
// Round-robin request picker: first requester at or after base, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] base,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Scan ports in rotated order and stop at the first request.
  always_comb begin
    int unsigned k;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (32'(base) + i) % N;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/io_bridge_arb.sv
// Registered multi-port Wishbone I/O bridge with round-robin arbitration,
// bus timeout and a 32-bit narrow view of the 64-bit master bus.
module io_bridge_arb
  import io_pkg::*;
#(
  parameter int unsigned         NPORTS   = 4,
  parameter int unsigned         AW       = 32,
  parameter int unsigned         WIN_BITS = 12,
  parameter logic [WIN_BITS-1:0] IO_BASE  = WIN_BITS'(IO_BASE_DEF),
  parameter int unsigned         TMO      = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NPORTS-1:0]      s_cyc_i,
  input  logic [NPORTS-1:0]      s_stb_i,
  input  logic [NPORTS-1:0]      s_we_i,
  input  logic [8*NPORTS-1:0]    s_sel_i,
  input  logic [AW*NPORTS-1:0]   s_adr_i,
  input  logic [64*NPORTS-1:0]   s_dat_i,
  output logic [NPORTS-1:0]      s_ack_o,
  output logic [NPORTS-1:0]      s_err_o,
  output logic [63:0]            s_dat_o,
  output logic                   m_cyc_o,
  output logic                   m_stb_o,
  output logic                   m_we_o,
  output logic [7:0]             m_sel_o,
  output logic [AW-1:0]          m_adr_o,
  output logic [63:0]            m_dat_o,
  input  logic                   m_ack_i,
  input  logic [63:0]            m_dat_i,
  output logic [3:0]             m_sel32_o,
  output logic [AW-1:0]          m_adr32_o,
  output logic [31:0]            m_dat32_o
);

  localparam int unsigned PW      = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [7:0]  TMO_CNT = 8'(TMO);

  io_state_e         state_q, state_d;
  logic [PW-1:0]     rr_q, gnt_q, ptr_next;
  logic [7:0]        cnt_q;
  logic              ok_q, err_q;
  logic [63:0]       rdata_q;

  logic [NPORTS-1:0] elig, arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_any;
  logic [7:0]        sel_g;
  logic [63:0]       dat_g;
  logic [AW-1:0]     adr_w;
  logic              grant, acked, abort, tmo, done;

  // A port is eligible when its cycle is open and it addresses the I/O window.
  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      elig[k] = s_cyc_i[k] && (s_adr_i[k*AW + AW-1 -: WIN_BITS] == IO_BASE);
    end
  end

  rr_arbiter #(.N(NPORTS), .PW(PW)) u_arb (
    .req  (elig),
    .base (rr_q),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  // Fields of the winning port; the window tag is forced onto the address.
  always_comb begin
    sel_g    = s_sel_i[arb_idx*8 +: 8];
    dat_g    = s_dat_i[arb_idx*64 +: 64];
    adr_w    = {IO_BASE, s_adr_i[arb_idx*AW +: (AW-WIN_BITS)]};
    ptr_next = (gnt_q == PW'(NPORTS-1)) ? '0 : gnt_q + 1'b1;
  end

  // Next-state and event decode; ack beats abort, abort beats timeout.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    acked   = 1'b0;
    abort   = 1'b0;
    tmo     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!m_ack_i && arb_any) begin
          grant   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (m_ack_i) begin
          acked   = 1'b1;
          state_d = WAIT_NACK;
        end else if (!s_cyc_i[gnt_q]) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if ((TMO != 0) && (cnt_q == TMO_CNT)) begin
          tmo     = 1'b1;
          state_d = WAIT_NACK;
        end
      end
      WAIT_NACK: begin
        if (!s_stb_i[gnt_q]) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Master-side capture, timeout counter, flags and registered slave responses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      m_sel32_o <= '0;
      m_adr32_o <= '0;
      m_dat32_o <= '0;
      s_ack_o   <= '0;
      s_err_o   <= '0;
      s_dat_o   <= '0;
    end else begin
      if (grant) begin
        gnt_q     <= arb_idx;
        cnt_q     <= '0;
        m_cyc_o   <= 1'b1;
        m_stb_o   <= 1'b1;
        m_we_o    <= |(s_we_i & arb_gnt);
        m_sel_o   <= sel_g;
        m_adr_o   <= adr_w;
        m_dat_o   <= dat_g;
        m_sel32_o <= sel_g[7:4] | sel_g[3:0];
        m_adr32_o <= {adr_w[AW-1:3], |sel_g[7:4], adr_w[1:0]};
        m_dat32_o <= lane_steer(|sel_g[7:4], dat_g);
      end
      if (state_q == WAIT_ACK && !acked && !abort && !tmo) cnt_q <= cnt_q + 8'd1;
      if (acked || abort || tmo) begin
        m_cyc_o <= 1'b0;
        m_stb_o <= 1'b0;
        m_we_o  <= 1'b0;
      end
      if (acked) begin
        rdata_q <= m_dat_i;
        ok_q    <= 1'b1;
      end
      if (tmo) err_q <= 1'b1;
      if (abort) rr_q <= ptr_next;

      // Responses are a registered image of the flags, gated by the granted strobe.
      s_ack_o <= '0;
      s_err_o <= '0;
      s_dat_o <= '0;
      if (state_q == WAIT_NACK && !done) begin
        s_ack_o[gnt_q] <= ok_q;
        s_err_o[gnt_q] <= err_q;
        if (ok_q) s_dat_o <= rdata_q;
      end
      if (done) begin
        ok_q  <= 1'b0;
        err_q <= 1'b0;
        rr_q  <= ptr_next;
      end
    end
  end

endmodule

// File: tb/tb_io_bridge_arb.sv
// Self-checking bench for io_bridge_arb: directed scenarios plus a randomized
// multi-port phase checked against a transaction-level round-robin model.
module tb_io_bridge_arb;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [3:0]    s_cyc_i, s_stb_i, s_we_i;
  logic [31:0]   s_sel_i;
  logic [127:0]  s_adr_i;
  logic [255:0]  s_dat_i;
  logic [3:0]    s_ack_o, s_err_o;
  logic [63:0]   s_dat_o;
  logic          m_cyc_o, m_stb_o, m_we_o;
  logic [7:0]    m_sel_o;
  logic [31:0]   m_adr_o;
  logic [63:0]   m_dat_o;
  logic          m_ack_i;
  logic [63:0]   m_dat_i;
  logic [3:0]    m_sel32_o;
  logic [31:0]   m_adr32_o;
  logic [31:0]   m_dat32_o;

  io_bridge_arb #(
    .NPORTS(4), .AW(32), .WIN_BITS(12), .IO_BASE(12'hFFD), .TMO(255)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_sel_i(s_sel_i),
    .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_ack_o(s_ack_o), .s_err_o(s_err_o),
    .s_dat_o(s_dat_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_sel_o(m_sel_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_ack_i(m_ack_i),
    .m_dat_i(m_dat_i), .m_sel32_o(m_sel32_o), .m_adr32_o(m_adr32_o),
    .m_dat32_o(m_dat32_o)
  );

  always #5 clk_i = ~clk_i;

  int nchk = 0;
  int nerr = 0;

  // Reference model state: per-port request descriptors and the fairness pointer.
  logic        on_a [4];
  logic        inw_a[4];
  logic        we_a [4];
  logic [7:0]  sel_a[4];
  logic [31:0] adr_a[4];
  logic [63:0] dat_a[4];
  int          rr_ptr;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] p, input logic we, input logic [7:0] sel,
                     input logic [31:0] adr, input logic [63:0] dat);
    on_a[p] = 1'b1; inw_a[p] = (adr[31:20] == 12'hFFD);
    we_a[p] = we; sel_a[p] = sel; adr_a[p] = adr; dat_a[p] = dat;
    s_cyc_i[p] = 1'b1; s_stb_i[p] = 1'b1; s_we_i[p] = we;
    s_sel_i[p*8 +: 8] = sel; s_adr_i[p*32 +: 32] = adr; s_dat_i[p*64 +: 64] = dat;
  endtask

  task automatic drop(input logic [1:0] p);
    on_a[p] = 1'b0;
    s_cyc_i[p] = 1'b0; s_stb_i[p] = 1'b0;
  endtask

  task automatic rand_req(input logic [1:0] p, input logic force_in);
    logic [31:0] r;
    logic [11:0] tag;
    r = $urandom;
    tag = (force_in || $urandom_range(0, 7) != 0) ? 12'hFFD : 12'($urandom_range(0, 12'hFFC));
    req(p, 1'($urandom_range(0, 1)), 8'($urandom), {tag, r[19:0]}, {$urandom, $urandom});
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    s_cyc_i = '0; s_stb_i = '0; s_we_i = '0; s_sel_i = '0; s_adr_i = '0; s_dat_i = '0;
    m_ack_i = 1'b0; m_dat_i = '0;
    for (int q = 0; q < 4; q++) on_a[q] = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    rr_ptr = 0;
  endtask

  // Spec rule: first eligible port at or after the pointer, wrapping.
  function automatic int pick(input logic [3:0] elig);
    for (int i = 0; i < 4; i++) if (elig[(rr_ptr + i) % 4]) return (rr_ptr + i) % 4;
    return -1;
  endfunction

  // Run one complete transaction for the port the model expects to win.
  task automatic serve(input logic [1:0] p, input int delay, input logic [63:0] rd);
    int n;
    logic hi;
    logic [31:0] fa;
    n = 0;
    while (!m_cyc_o && n < 20) begin tick(); n++; end
    check("grant_seen", m_cyc_o, 1);
    fa = {12'hFFD, adr_a[p][19:0]};
    hi = |sel_a[p][7:4];
    check("m_stb", m_stb_o, 1);
    check("m_adr", m_adr_o, fa);
    check("m_we", m_we_o, we_a[p]);
    check("m_sel", m_sel_o, sel_a[p]);
    check("m_dat", m_dat_o, dat_a[p]);
    check("m_sel32", m_sel32_o, sel_a[p][7:4] | sel_a[p][3:0]);
    check("m_adr32", m_adr32_o, {fa[31:3], hi, fa[1:0]});
    check("m_dat32", m_dat32_o, hi ? dat_a[p][63:32] : dat_a[p][31:0]);
    repeat (delay) tick();
    m_ack_i = 1'b1; m_dat_i = rd;
    tick();
    m_ack_i = 1'b0; m_dat_i = {$urandom, $urandom};
    check("m_cyc_drop", m_cyc_o, 0);
    n = 0;
    while (s_ack_o == 4'b0 && n < 5) begin tick(); n++; end
    check("s_ack", s_ack_o, 4'b0001 << p);
    check("s_dat", s_dat_o, rd);
    check("s_err", s_err_o, 0);
    drop(p);
    tick();
    check("s_ack_clr", s_ack_o, 0);
    check("s_dat_clr", s_dat_o, 0);
    rr_ptr = (p + 1) % 4;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, g;
    logic seen;
    logic [3:0] acc, elig;

    // Reset state.
    do_reset();
    check("rst_m_cyc", m_cyc_o, 0);
    check("rst_m_adr", m_adr_o, 0);
    check("rst_s_ack", s_ack_o, 0);
    check("rst_s_err", s_err_o, 0);
    check("rst_s_dat", s_dat_o, 0);

    // Single read on port 0, slave acks after 3 cycles.
    req(2'd0, 1'b0, 8'hFF, 32'hFFD00010, 64'h0);
    check("cyc_before", m_cyc_o, 0);
    tick();
    check("cyc_latency", m_cyc_o, 1);
    serve(2'd0, 3, 64'h0123456789ABCDEF);

    // Ports 0,1,2 request continuously: grants rotate 0,1,2,0,1,2.
    do_reset();
    req(2'd0, 1'b0, 8'h0F, 32'hFFD00100, 64'h1000);
    req(2'd1, 1'b1, 8'hF0, 32'hFFD00200, 64'h2000);
    req(2'd2, 1'b0, 8'hFF, 32'hFFD00300, 64'h3000);
    for (int i = 0; i < 6; i++) begin
      serve(2'(i % 3), 1, 64'(i) + 64'h55);
      req(2'(i % 3), we_a[i % 3], sel_a[i % 3], adr_a[i % 3], dat_a[i % 3]);
    end
    for (int q = 0; q < 3; q++) drop(2'(q));
    tick(); tick();

    // Out-of-window write on port 1 is never forwarded or acked.
    req(2'd1, 1'b1, 8'hFF, 32'hFFE00000, 64'h1234);
    seen = 1'b0; acc = '0;
    repeat (50) begin tick(); seen |= m_cyc_o; acc |= s_ack_o | s_err_o; end
    check("oow_m_cyc", seen, 0);
    check("oow_s_ack", acc, 0);
    drop(2'd1);

    // Port 3 upper-lane write: narrow view takes the high half.
    req(2'd3, 1'b1, 8'hF0, 32'hFFD00100, 64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    check("p3_sel32", m_sel32_o, 4'hF);
    check("p3_adr32_b2", m_adr32_o[2], 1);
    check("p3_dat32", m_dat32_o, 32'hAAAABBBB);
    serve(2'd3, 0, 64'hFEED);

    // Timeout: no master ack, error ack TMO+2 cycles after grant.
    req(2'd0, 1'b0, 8'hFF, 32'hFFD00020, 64'h0);
    tick();
    check("tmo_grant", m_cyc_o, 1);
    n = 0;
    while (s_err_o == 4'b0 && n < 400) begin tick(); n++; end
    check("tmo_cycles", n, 257);
    check("tmo_s_err", s_err_o, 4'b0001);
    check("tmo_s_ack", s_ack_o, 0);
    check("tmo_s_dat", s_dat_o, 0);
    check("tmo_m_cyc", m_cyc_o, 0);
    drop(2'd0);
    tick();
    check("tmo_err_clr", s_err_o, 0);
    rr_ptr = 1;

    // Abort: port 2 drops its cycle while waiting for the master.
    req(2'd2, 1'b0, 8'hFF, 32'hFFD00040, 64'h0);
    tick();
    check("abort_grant", m_cyc_o, 1);
    drop(2'd2);
    tick();
    check("abort_m_cyc", m_cyc_o, 0);
    acc = '0;
    repeat (5) begin tick(); acc |= s_ack_o | s_err_o; end
    check("abort_no_ack", acc, 0);
    rr_ptr = 3;
    req(2'd1, 1'b0, 8'h0F, 32'hFFD00050, 64'h0);
    req(2'd3, 1'b0, 8'hF0, 32'hFFD00060, 64'h0);
    g = pick({on_a[3] & inw_a[3], on_a[2] & inw_a[2], on_a[1] & inw_a[1], on_a[0] & inw_a[0]});
    serve(2'(g), 1, 64'hA5A5);
    g = pick({on_a[3] & inw_a[3], on_a[2] & inw_a[2], on_a[1] & inw_a[1], on_a[0] & inw_a[0]});
    serve(2'(g), 2, 64'h5A5A);

    // Randomized traffic against the round-robin model.
    for (int it = 0; it < 40; it++) begin
      for (int q = 0; q < 4; q++) begin
        if (on_a[q] && !inw_a[q] && $urandom_range(0, 1) == 1) drop(2'(q));
        if (!on_a[q] && $urandom_range(0, 1) == 1) rand_req(2'(q), 1'b0);
      end
      for (int q = 0; q < 4; q++) elig[q] = on_a[q] & inw_a[q];
      if (elig == 4'b0) begin
        g = $urandom_range(0, 3);
        rand_req(2'(g), 1'b1);
        elig[g] = 1'b1;
      end
      g = pick(elig);
      serve(2'(g), $urandom_range(0, 3), {$urandom, $urandom});
    end
    for (int q = 0; q < 4; q++) drop(2'(q));
    tick(); tick();

    // Reset in the middle of WAIT_ACK clears every output on the next edge.
    req(2'd0, 1'b1, 8'hFF, 32'hFFD00080, 64'hDEAD_BEEF_0000_1111);
    tick();
    check("mid_grant", m_cyc_o, 1);
    rst_ni = 1'b0;
    tick();
    check("mid_m_cyc", m_cyc_o, 0);
    check("mid_m_stb", m_stb_o, 0);
    check("mid_m_we", m_we_o, 0);
    check("mid_m_sel", m_sel_o, 0);
    check("mid_m_adr", m_adr_o, 0);
    check("mid_m_dat", m_dat_o, 0);
    check("mid_narrow", {m_sel32_o, m_adr32_o, m_dat32_o}, 0);
    check("mid_s_resp", {s_ack_o, s_err_o}, 0);
    check("mid_s_dat", s_dat_o, 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
